spi_slave_rw: RTL and testbench

Parametrised SPI mode-0 slave bridging an external SPI master onto the on-chip register bus, supporting both writes and reads. All SPI pins are oversampled and synchronised into the single system clock domain, so no logic is clocked by SCLK. Each frame carries one R/W bit, an AW-bit address and one or more DW-bit data words. It drives a single-cycle write strobe and a single-cycle read request toward the register file.

---
 rtl/spi_slave_rw.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_slave_rw.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rw.sv
`default_nettype none
// ==================================================================================
// spi_slave_rw: oversampled SPI mode-0 slave bridging to the register bus (rev 1.0)
// Build option SPI_SLAVE_RW_BURST_EN enables multi-word bursts with address increment
// ==================================================================================
module spi_slave_rw #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs_i,       // active-low chip select
  input  logic          sclk_i,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          miso_oe_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          wen_o,
  output logic          rreq_o,
  input  logic [DW-1:0] rdata_i
);

  localparam int SW = (AW > DW) ? AW : DW;
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] C_ALAST = CW'(AW - 1);
  localparam logic [CW-1:0] C_DLAST = CW'(DW - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  logic [1:0]    cs_s_q, sclk_s_q, mosi_s_q;
  logic          sclk_prev_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-2:0] sh_q;
  logic          rw_q, armed_q, first_fall_q, ld_tx_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, tx_q;
  logic          wen_q, wen_pend_q, rreq_q, rreq_pend_q, oe_q;
`ifdef SPI_SLAVE_RW_BURST_EN
  logic [DW-1:0] nxt_q;
  logic          ld_next_q, inc_wr_q;
`endif

  logic          cs_hi, mosi_s, sclk_rise, sclk_fall;
  logic [SW-1:0] sh_d;

  assign cs_hi     = cs_s_q[1];
  assign mosi_s    = mosi_s_q[1];
  assign sclk_rise = sclk_s_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s_q[1] & sclk_prev_q;
  assign sh_d      = {sh_q, mosi_s};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_s_q      <= '0;
      sclk_s_q    <= '0;
      mosi_s_q    <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_s_q      <= {cs_s_q[0], cs_i};
      sclk_s_q    <= {sclk_s_q[0], sclk_i};
      mosi_s_q    <= {mosi_s_q[0], mosi_i};
      sclk_prev_q <= sclk_s_q[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      rw_q         <= 1'b0;
      armed_q      <= 1'b0;
      first_fall_q <= 1'b0;
      ld_tx_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tx_q         <= '0;
      oe_q         <= 1'b0;
      wen_q        <= 1'b0;
      wen_pend_q   <= 1'b0;
      rreq_q       <= 1'b0;
      rreq_pend_q  <= 1'b0;
`ifdef SPI_SLAVE_RW_BURST_EN
      nxt_q        <= '0;
      ld_next_q    <= 1'b0;
      inc_wr_q     <= 1'b0;
`endif
    end else begin
      wen_q       <= wen_pend_q;
      wen_pend_q  <= 1'b0;
      rreq_q      <= rreq_pend_q;
      rreq_pend_q <= 1'b0;
      // Armed only after CS is seen high, so a frame already in flight at reset is ignored
      if (cs_hi) armed_q <= 1'b1;

      if (rreq_q && state_q == S_DATA) begin
        if (ld_tx_q) begin
          tx_q <= rdata_i;
          oe_q <= 1'b1;
        end
`ifdef SPI_SLAVE_RW_BURST_EN
        else begin
          nxt_q <= rdata_i;
        end
`endif
      end

      if (cs_hi && state_q != S_IDLE) begin
        state_q      <= S_IDLE;
        tx_q         <= '0;
        oe_q         <= 1'b0;
        first_fall_q <= 1'b0;
        ld_tx_q      <= 1'b0;
`ifdef SPI_SLAVE_RW_BURST_EN
        ld_next_q    <= 1'b0;
        inc_wr_q     <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (armed_q && !cs_hi) begin
              state_q <= S_CMD;
              cnt_q   <= '0;
              armed_q <= 1'b0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              rw_q    <= mosi_s;
              cnt_q   <= '0;
              state_q <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (sclk_rise) begin
              sh_q <= sh_d[SW-2:0];
              if (cnt_q == C_ALAST) begin
                addr_q       <= sh_d[AW-1:0];
                cnt_q        <= '0;
                state_q      <= S_DATA;
                first_fall_q <= 1'b1;
                if (rw_q) begin
                  rreq_pend_q <= 1'b1;
                  ld_tx_q     <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          S_DATA: begin
            if (sclk_rise) begin
              sh_q <= sh_d[SW-2:0];
              if (cnt_q == C_DLAST) begin
                cnt_q <= '0;
                if (!rw_q) begin
                  wdata_q    <= sh_d[DW-1:0];
                  wen_pend_q <= 1'b1;
                end
`ifdef SPI_SLAVE_RW_BURST_EN
                // Reads prefetch the next address now; writes keep ADDR stable under WEN
                if (rw_q) begin
                  addr_q      <= addr_q + 1'b1;
                  rreq_pend_q <= 1'b1;
                  ld_tx_q     <= 1'b0;
                  ld_next_q   <= 1'b1;
                end else begin
                  inc_wr_q <= 1'b1;
                end
`else
                state_q <= S_DONE;
                tx_q    <= '0;
                oe_q    <= 1'b0;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else if (sclk_fall) begin
              first_fall_q <= 1'b0;
              if (rw_q && !first_fall_q) begin
`ifdef SPI_SLAVE_RW_BURST_EN
                if (ld_next_q) begin
                  tx_q      <= nxt_q;
                  ld_next_q <= 1'b0;
                end else begin
                  tx_q <= tx_q << 1;
                end
`else
                tx_q <= tx_q << 1;
`endif
              end
`ifdef SPI_SLAVE_RW_BURST_EN
              if (inc_wr_q) begin
                addr_q   <= addr_q + 1'b1;
                inc_wr_q <= 1'b0;
              end
`endif
            end
          end
          S_DONE: begin
            tx_q <= '0;
            oe_q <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign miso_o    = tx_q[DW-1];
  assign miso_oe_o = oe_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign wen_o     = wen_q;
  assign rreq_o    = rreq_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rw.sv
`default_nettype none
// ==================================================================================
// tb_spi_slave_rw: directed scoreboard bench for spi_slave_rw at 8-bit and 16-bit widths
// ==================================================================================
module tb_spi_slave_rw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs8 = 1'b1, cs16 = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic        miso8, oe8, wen8, rreq8, miso16, oe16, wen16, rreq16;
  logic [7:0]  addr8, wdata8, rdata8 = '0;
  logic [15:0] addr16, wdata16, rdata16 = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_rise = 0;

  typedef struct {
    logic        d16;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  logic [15:0] tx_words[4];
  logic [15:0] rx_words[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_rw #(.AW(8), .DW(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .cs_i(cs8), .sclk_i(sclk), .mosi_i(mosi),
    .miso_o(miso8), .miso_oe_o(oe8), .addr_o(addr8), .wdata_o(wdata8),
    .wen_o(wen8), .rreq_o(rreq8), .rdata_i(rdata8)
  );

  spi_slave_rw #(.AW(16), .DW(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .cs_i(cs16), .sclk_i(sclk), .mosi_i(mosi),
    .miso_o(miso16), .miso_oe_o(oe16), .addr_o(addr16), .wdata_o(wdata16),
    .wen_o(wen16), .rreq_o(rreq16), .rdata_i(rdata16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic d16, input logic rd, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.d16 = d16; e.rd = rd; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Pops the expected bus event, checks it, and answers reads from the bench's own table
  task automatic handle(input logic d16, input logic rd, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ev_dut", {31'd0, d16}, {31'd0, e.d16});
      check("ev_kind", {31'd0, rd}, {31'd0, e.rd});
      check("ev_addr", {16'd0, a}, {16'd0, e.addr});
      if (!rd) check("ev_wdata", {16'd0, d}, {16'd0, e.data});
      else if (d16) rdata16 = e.data;
      else rdata8 = e.data[7:0];
      check("ev_latency", cyc - last_rise, 32'd4);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wen8)   handle(1'b0, 1'b0, {8'h00, addr8}, {8'h00, wdata8});
      if (rreq8)  handle(1'b0, 1'b1, {8'h00, addr8}, 16'h0000);
      if (wen16)  handle(1'b1, 1'b0, addr16, wdata16);
      if (rreq16) handle(1'b1, 1'b1, addr16, 16'h0000);
    end
  end

  task automatic sbit(input logic d16, input logic b, input int h, output logic m, output logic oe);
    mosi = b;
    repeat (h) @(negedge clk);
    m  = d16 ? miso16 : miso8;
    oe = d16 ? oe16 : oe8;
    sclk = 1'b1;
    last_rise = cyc;
    repeat (h) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic d16, input logic rw, input logic [15:0] addr, input int nw,
                       input int h, input int abort_bits, input int rst_bit);
    int   aw;
    int   k;
    logic m, oe;
    aw = d16 ? 16 : 8;
    k  = 1;
    if (d16) cs16 = 1'b0; else cs8 = 1'b0;
    repeat (h) @(negedge clk);
    sbit(d16, rw, h, m, oe);
    for (int i = aw - 1; i >= 0; i--) begin
      if (k == rst_bit) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_addr", {24'd0, addr8}, 32'd0);
        check("rst_wdata", {24'd0, wdata8}, 32'd0);
        check("rst_strobes", {30'd0, wen8, rreq8}, 32'd0);
        check("rst_miso", {30'd0, miso8, oe8}, 32'd0);
        rst = 1'b0;
      end
      sbit(d16, addr[i], h, m, oe);
      k++;
      if (rw && i == 0) check("oe_in_addr", {31'd0, oe}, 32'd0);
    end
    for (int w = 0; w < nw; w++) begin
      for (int i = aw - 1; i >= 0; i--) begin
        if (!(abort_bits >= 0 && (aw - 1 - i) >= abort_bits)) begin
          sbit(d16, tx_words[w][i], h, m, oe);
          rx_words[w][i] = m;
          if (rw && w == 0 && i == aw - 1) check("oe_in_data", {31'd0, oe}, 32'd1);
        end
      end
    end
    repeat (h) @(negedge clk);
    if (d16) cs16 = 1'b1; else cs8 = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs8", {addr8, wdata8, 4'd0, wen8, rreq8, miso8, oe8}, 32'd0);
    check("reset_outputs16", {addr16, wdata16}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single write
    tx_words[0] = 16'h00A5;
    push(1'b0, 1'b0, 16'h003C, 16'h00A5);
    frame(1'b0, 1'b0, 16'h003C, 1, 5, -1, -1);
    check("wdata_hold", {24'd0, wdata8}, 32'h0000_00A5);
    check("addr_hold", {24'd0, addr8}, 32'h0000_003C);

    // Single read
    push(1'b0, 1'b1, 16'h0010, 16'h005A);
    frame(1'b0, 1'b1, 16'h0010, 1, 4, -1, -1);
    check("read_miso", {24'd0, rx_words[0][7:0]}, 32'h0000_005A);
    check("oe_after_read", {31'd0, oe8}, 32'd0);

    // Abort after 5 data bits, then a clean write
    tx_words[0] = 16'h00FF;
    frame(1'b0, 1'b0, 16'h0044, 1, 4, 5, -1);
    check("abort_no_wen", sb.size(), 32'd0);
    tx_words[0] = 16'h0077;
    push(1'b0, 1'b0, 16'h0001, 16'h0077);
    frame(1'b0, 1'b0, 16'h0001, 1, 4, -1, -1);

    // Multi-word write
    tx_words[0] = 16'h0011; tx_words[1] = 16'h0022; tx_words[2] = 16'h0033;
    push(1'b0, 1'b0, 16'h00FE, 16'h0011);
`ifdef SPI_SLAVE_RW_BURST_EN
    push(1'b0, 1'b0, 16'h00FF, 16'h0022);
    push(1'b0, 1'b0, 16'h0000, 16'h0033);
`endif
    frame(1'b0, 1'b0, 16'h00FE, 3, 4, -1, -1);
    check("multi_write_drained", sb.size(), 32'd0);

`ifdef SPI_SLAVE_RW_BURST_EN
    // Burst read; the end of the second word prefetches 0x22
    push(1'b0, 1'b1, 16'h0020, 16'h00C3);
    push(1'b0, 1'b1, 16'h0021, 16'h003C);
    push(1'b0, 1'b1, 16'h0022, 16'h0000);
    frame(1'b0, 1'b1, 16'h0020, 2, 4, -1, -1);
    check("burst_rd0", {24'd0, rx_words[0][7:0]}, 32'h0000_00C3);
    check("burst_rd1", {24'd0, rx_words[1][7:0]}, 32'h0000_003C);
`else
    check("nonburst_wdata", {24'd0, wdata8}, 32'h0000_0011);
`endif

    // Reset during the address phase with CS held low
    tx_words[0] = 16'h0099;
    frame(1'b0, 1'b0, 16'h0055, 1, 4, -1, 4);
    check("rst_frame_ignored", sb.size(), 32'd0);
    tx_words[0] = 16'h0024;
    push(1'b0, 1'b0, 16'h0042, 16'h0024);
    frame(1'b0, 1'b0, 16'h0042, 1, 4, -1, -1);

    // 16-bit, minimum SCLK phases: write then read back
    tx_words[0] = 16'hBEEF;
    push(1'b1, 1'b0, 16'h1234, 16'hBEEF);
    frame(1'b1, 1'b0, 16'h1234, 1, 4, -1, -1);
    push(1'b1, 1'b1, 16'h1234, 16'hBEEF);
    frame(1'b1, 1'b1, 16'h1234, 1, 4, -1, -1);
    check("rd16_miso", {16'd0, rx_words[0]}, 32'h0000_BEEF);
    check("wdata16", {16'd0, wdata16}, 32'h0000_BEEF);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
